// File: rtl/pnr_pkg.sv
// Shared types and constants for the photon-number-resolving pulse classifier.
// Thresholds travel as a packed array with index 0 holding threshold_1.
package pnr_pkg;

    localparam int ADC_W  = 14;
    localparam int N_THR  = 7;
    localparam int PNUM_W = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEASURE,
        S_CLASSIFY,
        S_HOLDOFF
    } state_t;

    typedef logic signed [ADC_W-1:0] sample_t;
    typedef sample_t [N_THR-1:0]     thr_arr_t;

endpackage

// File: rtl/pnr_threshold_encoder.sv
// Signed peak vs. seven thresholds -> number of thresholds met (0..7).
// Thresholds need not be monotonic, so this is a true popcount.
module pnr_threshold_encoder
    import pnr_pkg::*;
(
    input  sample_t             peak,
    input  thr_arr_t            thr,
    output logic [PNUM_W-1:0]   count
);

    always_comb begin
        count = '0;
        for (int k = 0; k < N_THR; k++) begin
            if (peak >= $signed(thr[k]))
                count = count + PNUM_W'(1);
        end
    end

endmodule

// File: rtl/pnr_pulse_classifier.sv
// Detects ADC pulses above threshold_1, tracks the peak and classifies it into a
// photon number; a hold-off plus below-threshold condition gates re-arming.
module pnr_pulse_classifier
    import pnr_pkg::*;
#(
    parameter int MAX_LEN = 64,
    parameter int HOLDOFF = 32
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                en_i,
    input  logic [ADC_W-1:0]    adc_dat_i,
    input  logic [ADC_W-1:0]    adc_photon_threshold_1,
    input  logic [ADC_W-1:0]    adc_photon_threshold_2,
    input  logic [ADC_W-1:0]    adc_photon_threshold_3,
    input  logic [ADC_W-1:0]    adc_photon_threshold_4,
    input  logic [ADC_W-1:0]    adc_photon_threshold_5,
    input  logic [ADC_W-1:0]    adc_photon_threshold_6,
    input  logic [ADC_W-1:0]    adc_photon_threshold_7,
    output logic [PNUM_W-1:0]   photon_num_o,
    output logic                valid_o,
    output logic                long_o,
    output logic                busy_o
);

    localparam int LEN_W = $clog2(MAX_LEN) + 1;
    localparam int HO_W  = $clog2(HOLDOFF) + 1;

    state_t             state, state_nxt;
    sample_t            sample, peak;
    thr_arr_t           thr_live, thr_lat;
    logic [LEN_W-1:0]   len;
    logic [HO_W-1:0]    ho_cnt;
    logic               long_flag;
    logic [PNUM_W-1:0]  count;
    logic               arm_live, above, len_max, ho_done, fire;

    assign sample   = $signed(adc_dat_i);
    assign thr_live = {adc_photon_threshold_7, adc_photon_threshold_6,
                       adc_photon_threshold_5, adc_photon_threshold_4,
                       adc_photon_threshold_3, adc_photon_threshold_2,
                       adc_photon_threshold_1};

    // Arming and hold-off exit use the live level; an in-flight pulse uses its latched one.
    assign arm_live = sample >= $signed(thr_live[0]);
    assign above    = sample >= $signed(thr_lat[0]);
    assign len_max  = len == LEN_W'(MAX_LEN - 1);
    assign ho_done  = ho_cnt == HO_W'(HOLDOFF - 1);

    pnr_threshold_encoder u_enc (
        .peak  (peak),
        .thr   (thr_lat),
        .count (count)
    );

    always_ff @(posedge clk_i) begin
        if (!rstn_i)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!en_i) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:     if (arm_live)           state_nxt = S_MEASURE;
                S_MEASURE:  if (!above || len_max)  state_nxt = S_CLASSIFY;
                S_CLASSIFY:                         state_nxt = S_HOLDOFF;
                S_HOLDOFF:  if (ho_done && !arm_live) state_nxt = S_IDLE;
                default:                            state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o = state != S_IDLE;
        fire   = en_i && (state == S_CLASSIFY);
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            photon_num_o <= '0;
            valid_o      <= 1'b0;
            long_o       <= 1'b0;
            peak         <= '0;
            thr_lat      <= '0;
            len          <= '0;
            ho_cnt       <= '0;
            long_flag    <= 1'b0;
        end else begin
            valid_o <= fire;
            if (fire) begin
                photon_num_o <= count;
                long_o       <= long_flag;
            end
            case (state)
                S_IDLE: begin
                    if (en_i && arm_live) begin
                        thr_lat   <= thr_live;
                        peak      <= sample;
                        len       <= LEN_W'(1);
                        long_flag <= 1'b0;
                    end
                end
                S_MEASURE: begin
                    if (above) begin
                        if (sample > peak)
                            peak <= sample;
                        if (len_max)
                            long_flag <= 1'b1;
                        else
                            len <= len + LEN_W'(1);
                    end
                end
                S_CLASSIFY: ho_cnt <= '0;
                S_HOLDOFF: begin
                    if (!ho_done)
                        ho_cnt <= ho_cnt + HO_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
